// File: rtl/ram_async_ctrl.sv
// Controller for an asynchronous SRAM with registered chip-select, write-enable
// and output-enable. Each transaction is SETUP -> STROBE (WAIT_CYCLES) -> HOLD,
// so address and write data are stable before and after the strobe.
module ram_async_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_address,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe
);

  // A zero strobe length is treated as one cycle; the counter is 4 bits wide.
  localparam int W_EFF = (WAIT_CYCLES < 1)  ? 1  :
                         (WAIT_CYCLES > 15) ? 15 : WAIT_CYCLES;
  localparam logic [3:0] CNT_LOAD = 4'(W_EFF - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  op_we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  cs_q;
  logic                  rwe_q;
  logic                  oe_q;
  logic                  drv_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  ready_q;
  logic                  busy_q;

  // Sequencer: every RAM-facing and host-facing output is produced as a register.
  // drv_q is only ever set for write transactions, so the bus cannot be driven
  // while ram_oe is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_we_q     <= 1'b0;
      wdata_q     <= '0;
      addr_q      <= '0;
      cs_q        <= 1'b0;
      rwe_q       <= 1'b0;
      oe_q        <= 1'b0;
      drv_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && ready_q) begin
            op_we_q <= req_we;
            wdata_q <= req_wdata;
            addr_q  <= req_addr;
            cs_q    <= 1'b1;
            drv_q   <= req_we;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          cnt_q   <= CNT_LOAD;
          rwe_q   <= op_we_q;
          oe_q    <= ~op_we_q;
          state_q <= STROBE;
        end
        STROBE: begin
          if (cnt_q == 4'd0) begin
            rwe_q   <= 1'b0;
            oe_q    <= 1'b0;
            if (!op_we_q) begin
              rdata_q     <= ram_data;
              rsp_valid_q <= 1'b1;
            end
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: begin
          cs_q        <= 1'b0;
          drv_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_data    = drv_q ? wdata_q : {DATA_WIDTH{1'bz}};
  assign ram_address = addr_q;
  assign ram_cs      = cs_q;
  assign ram_we      = rwe_q;
  assign ram_oe      = oe_q;
  assign req_ready   = ready_q;
  assign busy        = busy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;

endmodule

// File: tb/tb_ram_async_ctrl.sv
// Bench for ram_async_ctrl: three instances (WAIT_CYCLES 1, 3, 0) share one
// host stimulus, each with its own RAM model. A transaction-level model
// (cycle offset since acceptance) predicts every output each cycle; literal
// expectations pin the key timing points.
module tb_ram_async_ctrl;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset, req_valid, req_we, mem_init;
  logic [7:0] req_addr, req_wdata;

  wire [NI-1:0]      req_ready, rsp_valid, busy, ram_cs, ram_we, ram_oe;
  wire [NI-1:0][7:0] rsp_rdata, ram_address, dbus;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int WR = (g == 0) ? 1 : (g == 1) ? 3 : 0;
    wire  [7:0] bus;
    logic [7:0] mem [256];

    ram_async_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_CYCLES(WR)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[g]),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .busy(busy[g]),
      .ram_address(ram_address[g]), .ram_data(bus), .ram_cs(ram_cs[g]),
      .ram_we(ram_we[g]), .ram_oe(ram_oe[g])
    );

    // RAM: drives the bus only while selected and output-enabled
    assign bus     = (ram_cs[g] && ram_oe[g]) ? mem[ram_address[g]] : 8'hzz;
    assign dbus[g] = bus;

    always @(posedge clk) begin
      if (mem_init) begin
        for (int a = 0; a < 256; a++) mem[a] <= 8'h00;
      end else if (ram_cs[g] && ram_we[g]) begin
        mem[ram_address[g]] <= bus;
      end
    end
  end

  // ---------------- transaction-level model ----------------
  int         m_k   [NI];   // 0 = idle, else cycle offset since acceptance
  logic       m_wr  [NI];
  logic [7:0] m_addr[NI];
  logic [7:0] m_wd  [NI];
  logic [7:0] m_rd  [NI];
  logic [7:0] ref_mem [NI][256];

  function automatic int weff(input int i);
    int raw;
    raw = (i == 0) ? 1 : (i == 1) ? 3 : 0;
    return (raw < 1) ? 1 : raw;
  endfunction

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      int w;
      w = weff(i);
      if (reset) begin
        m_k[i] = 0; m_addr[i] = 8'h00; m_rd[i] = 8'h00;
      end else if (m_k[i] == 0) begin
        if (req_valid) begin
          m_k[i] = 1; m_wr[i] = req_we; m_addr[i] = req_addr; m_wd[i] = req_wdata;
          if (req_we) ref_mem[i][req_addr] = req_wdata;
        end
      end else if (m_k[i] == w + 2) begin
        m_k[i] = 0;
      end else begin
        if (m_k[i] == w + 1 && !m_wr[i]) m_rd[i] = ref_mem[i][m_addr[i]];
        m_k[i] = m_k[i] + 1;
      end
    end
  endtask

  task automatic chkb(input string nm, input int i, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] t=%0t: got %b expected %b", nm, i, $time, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] t=%0t: got %h expected %h", nm, i, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      int   k, w;
      logic strb;
      k    = m_k[i];
      w    = weff(i);
      strb = (k >= 2) && (k <= w + 1);
      chkb("cs", i, ram_cs[i], k != 0);
      chkb("we", i, ram_we[i], m_wr[i] && strb);
      chkb("oe", i, ram_oe[i], !m_wr[i] && strb);
      chkb("rsp_valid", i, rsp_valid[i], !m_wr[i] && (k == w + 2));
      chkb("req_ready", i, req_ready[i], k == 0);
      chkb("busy", i, busy[i], k != 0);
      chk8("address", i, ram_address[i], m_addr[i]);
      chk8("rdata", i, rsp_rdata[i], m_rd[i]);
      if (k != 0 && m_wr[i])  chk8("wr_bus", i, dbus[i], m_wd[i]);
      else if (!m_wr[i] && strb) chk8("rd_bus", i, dbus[i], ref_mem[i][m_addr[i]]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_req(input logic we, input logic [7:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
  endtask

  // One read; per-cycle literal timing for the three strobe lengths.
  task automatic read_table(input logic [7:0] a, input logic [7:0] exp);
    logic [5:0] oe_w1, oe_w3, rv_w1, rv_w3;
    oe_w1 = 6'b000010; oe_w3 = 6'b001110;
    rv_w1 = 6'b000100; rv_w3 = 6'b010000;
    set_req(1'b0, a, 8'h00);
    for (int j = 0; j < 6; j++) begin
      tick();
      if (j == 0) req_valid = 1'b0;
      chkb("lit_oe_w1", 0, ram_oe[0], oe_w1[j]);
      chkb("lit_oe_w3", 1, ram_oe[1], oe_w3[j]);
      chkb("lit_oe_w0", 2, ram_oe[2], oe_w1[j]);
      chkb("lit_rv_w1", 0, rsp_valid[0], rv_w1[j]);
      chkb("lit_rv_w3", 1, rsp_valid[1], rv_w3[j]);
      chkb("lit_rv_w0", 2, rsp_valid[2], rv_w1[j]);
      if (j == 1) chk8("lit_rd_bus", 0, dbus[0], exp);
      if (j == 2) chk8("lit_rdata_w1", 0, rsp_rdata[0], exp);
      if (j == 4) chk8("lit_rdata_w3", 1, rsp_rdata[1], exp);
    end
  endtask

  initial begin
    int cnt, first, second;
    logic prev;
    for (int i = 0; i < NI; i++) begin
      m_k[i] = 0; m_wr[i] = 1'b0; m_addr[i] = 8'h00; m_wd[i] = 8'h00; m_rd[i] = 8'h00;
      for (int a = 0; a < 256; a++) ref_mem[i][a] = 8'h00;
    end
    mem_init = 1'b1;
    reset = 1'b1;
    set_req(1'b1, 8'h55, 8'h77);        // request present during reset
    tick(); tick();
    for (int i = 0; i < NI; i++) begin
      chkb("rst_ready", i, req_ready[i], 1'b1);
      chkb("rst_cs", i, ram_cs[i], 1'b0);
      chkb("rst_busy", i, busy[i], 1'b0);
      chk8("rst_rdata", i, rsp_rdata[i], 8'h00);
      chk8("rst_addr", i, ram_address[i], 8'h00);
    end
    reset = 1'b0; req_valid = 1'b0; mem_init = 1'b0;
    tick();
    chkb("no_accept_cs", 0, ram_cs[0], 1'b0);

    // write 0x10 <- 0xA5
    set_req(1'b1, 8'h10, 8'hA5);
    tick(); req_valid = 1'b0;
    chkb("w_setup_cs", 0, ram_cs[0], 1'b1);
    chkb("w_setup_we", 0, ram_we[0], 1'b0);
    chk8("w_setup_bus", 0, dbus[0], 8'hA5);
    tick();
    chkb("w_strobe_we", 0, ram_we[0], 1'b1);
    chk8("w_strobe_bus", 0, dbus[0], 8'hA5);
    tick();
    chkb("w_hold_we", 0, ram_we[0], 1'b0);
    chkb("w_hold_cs", 0, ram_cs[0], 1'b1);
    chk8("w_hold_bus", 0, dbus[0], 8'hA5);
    tick();
    chkb("w_ready", 0, req_ready[0], 1'b1);
    chkb("w_idle_cs", 0, ram_cs[0], 1'b0);
    tick(); tick();

    read_table(8'h10, 8'hA5);
    read_table(8'h00, 8'h00);

    // back-to-back: write 0xFF <- 0x3C then read 0xFF with req_valid held
    set_req(1'b1, 8'hFF, 8'h3C);
    prev = ram_cs[0]; cnt = 0; first = -1; second = -1;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (ram_cs[0] && !prev) begin
        cnt++;
        if (first < 0) first = j; else second = j;
      end
      prev = ram_cs[0];
      if (j == 0) begin req_we = 1'b0; req_wdata = 8'h00; end
      if (j == 4) req_valid = 1'b0;
    end
    chk8("b2b_count", 0, 8'(cnt), 8'd2);
    chk8("b2b_gap", 0, 8'(second - first), 8'd4);
    chk8("b2b_rdata", 0, rsp_rdata[0], 8'h3C);
    chk8("b2b_rdata_w0", 2, rsp_rdata[2], 8'h3C);

    // reset during STROBE of a write
    set_req(1'b1, 8'h20, 8'h5A);
    tick(); req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < NI; i++) begin
      chkb("abort_cs", i, ram_cs[i], 1'b0);
      chkb("abort_we", i, ram_we[i], 1'b0);
      chkb("abort_oe", i, ram_oe[i], 1'b0);
      chkb("abort_ready", i, req_ready[i], 1'b1);
      chkb("abort_rv", i, rsp_valid[i], 1'b0);
    end
    reset = 1'b0;
    tick();
    chkb("abort_rv2", 0, rsp_valid[0], 1'b0);
    chk8("abort_rdata", 0, rsp_rdata[0], 8'h00);

    read_table(8'h20, 8'h5A);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
